add_sched: RTL

ADD_SCHED -- requirements
Module: add_sched

---
 rtl/add_sched.sv | 210 +++++++++++++++++++++
 1 files changed

// File: rtl/add_sched.sv
// add_sched -- shares one external modular adder between a Kyber lane
// (two packed 12-bit coefficients, mode 0) and a Dilithium lane (one
// 24-bit coefficient, mode 1). Grants come in bursts of up to BURST_MAX
// transfers. A changeover between lanes always passes through a one-cycle
// SWITCH bubble, and the adder mode register changes only on entry to it.
// Optional build macro: ADD_SCHED_PERF_EN adds saturating 16-bit grant and
// switch counters as extra outputs.
//
// Handshake semantics: a transfer happens in a cycle where valid && ready
// are both high. A source holds valid and data stable until it sees ready.
// A sink's ready never depends on that same sink's valid. A response is
// held (valid and data stable) until it is taken with rsp_ready.
module add_sched #(
    parameter int BURST_MAX = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        k_req_valid,
    output logic        k_req_ready,
    input  logic [23:0] k_a,
    input  logic [23:0] k_b,
    input  logic        d_req_valid,
    output logic        d_req_ready,
    input  logic [23:0] d_a,
    input  logic [23:0] d_b,
    output logic [23:0] add_a,
    output logic [23:0] add_b,
    output logic        add_mode,
    input  logic [23:0] add_sum,
    output logic        k_rsp_valid,
    input  logic        k_rsp_ready,
    output logic [23:0] k_rsp_data,
    output logic        d_rsp_valid,
    input  logic        d_rsp_ready,
    output logic [23:0] d_rsp_data,
    output logic [1:0]  dbg_state,
    output logic [7:0]  dbg_cnt
`ifdef ADD_SCHED_PERF_EN
    ,
    output logic [15:0] k_grant_cnt,
    output logic [15:0] d_grant_cnt,
    output logic [15:0] switch_cnt
`endif
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_KYB    = 2'd1,
        S_DIL    = 2'd2,
        S_SWITCH = 2'd3
    } state_t;

    localparam logic [7:0] CNT_LAST = 8'(BURST_MAX - 1);

    state_t      state;
    logic [7:0]  cnt;
    logic        last_owner;   // 0 = Kyber, 1 = Dilithium
    logic        target;       // lane entered after the SWITCH bubble
    logic        mode_q;

    logic        k_xfer;
    logic        d_xfer;
    logic        any_valid;
    logic        winner;
    logic        own_valid;
    logic        oth_valid;
    logic        own_xfer;
    logic        burst_end;
    logic        switch_enter;
    logic        switch_to;

    assign add_mode  = mode_q;
    assign dbg_state = state;
    assign dbg_cnt   = cnt;

    // Readiness, transfer detection, operand steering and arbitration decisions
    always_comb begin
        k_req_ready = (state == S_KYB) && (!k_rsp_valid || k_rsp_ready);
        d_req_ready = (state == S_DIL) && (!d_rsp_valid || d_rsp_ready);
        k_xfer      = k_req_valid && k_req_ready;
        d_xfer      = d_req_valid && d_req_ready;

        add_a = 24'd0;
        add_b = 24'd0;
        if (k_xfer) begin
            add_a = k_a;
            add_b = k_b;
        end else if (d_xfer) begin
            add_a = d_a;
            add_b = d_b;
        end

        any_valid = k_req_valid || d_req_valid;
        // When both lanes ask, the one that did not own the adder last wins.
        winner    = (k_req_valid && d_req_valid) ? ~last_owner : d_req_valid;
        own_valid = (state == S_DIL) ? d_req_valid : k_req_valid;
        oth_valid = (state == S_DIL) ? k_req_valid : d_req_valid;
        own_xfer  = k_xfer || d_xfer;
        burst_end = (cnt == CNT_LAST);

        switch_enter = 1'b0;
        switch_to    = 1'b0;
        case (state)
            S_IDLE: begin
                if (any_valid && (winner != mode_q)) begin
                    switch_enter = 1'b1;
                    switch_to    = winner;
                end
            end
            S_KYB, S_DIL: begin
                if (((own_xfer && burst_end) || !own_valid) && oth_valid) begin
                    switch_enter = 1'b1;
                    switch_to    = (state == S_KYB);
                end
            end
            default: ;
        endcase
    end

    // Scheduler FSM: state, burst counter, adder mode and fairness history
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            cnt        <= 8'd0;
            mode_q     <= 1'b0;
            last_owner <= 1'b1;
            target     <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (any_valid) begin
                        cnt <= 8'd0;
                        if (switch_enter) begin
                            state  <= S_SWITCH;
                            target <= switch_to;
                            mode_q <= switch_to;
                        end else begin
                            state <= winner ? S_DIL : S_KYB;
                        end
                    end
                end
                S_SWITCH: begin
                    state <= target ? S_DIL : S_KYB;
                    cnt   <= 8'd0;
                end
                default: begin
                    if (own_xfer) begin
                        last_owner <= (state == S_DIL);
                        cnt        <= burst_end ? 8'd0 : cnt + 8'd1;
                    end else if (!own_valid) begin
                        cnt <= 8'd0;
                        if (!switch_enter) begin
                            state <= S_IDLE;
                        end
                    end
                    if (switch_enter) begin
                        state  <= S_SWITCH;
                        target <= switch_to;
                        mode_q <= switch_to;
                    end
                end
            endcase
        end
    end

    // Response registers: capture the adder result on a transfer, hold until taken
    always_ff @(posedge clk) begin
        if (rst) begin
            k_rsp_valid <= 1'b0;
            k_rsp_data  <= 24'd0;
            d_rsp_valid <= 1'b0;
            d_rsp_data  <= 24'd0;
        end else begin
            if (k_xfer) begin
                k_rsp_valid <= 1'b1;
                k_rsp_data  <= add_sum;
            end else if (k_rsp_ready) begin
                k_rsp_valid <= 1'b0;
            end
            if (d_xfer) begin
                d_rsp_valid <= 1'b1;
                d_rsp_data  <= add_sum;
            end else if (d_rsp_ready) begin
                d_rsp_valid <= 1'b0;
            end
        end
    end

`ifdef ADD_SCHED_PERF_EN
    // Saturating activity counters for grants and lane changeovers
    always_ff @(posedge clk) begin
        if (rst) begin
            k_grant_cnt <= 16'd0;
            d_grant_cnt <= 16'd0;
            switch_cnt  <= 16'd0;
        end else begin
            if (k_xfer && (k_grant_cnt != 16'hFFFF)) begin
                k_grant_cnt <= k_grant_cnt + 16'd1;
            end
            if (d_xfer && (d_grant_cnt != 16'hFFFF)) begin
                d_grant_cnt <= d_grant_cnt + 16'd1;
            end
            if (switch_enter && (switch_cnt != 16'hFFFF)) begin
                switch_cnt <= switch_cnt + 16'd1;
            end
        end
    end
`endif

endmodule
